// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with glitch filter, frame checker, prefix decoder and event FIFO
module ps2_keyboard_rx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            ps2_clk,
   input  logic                            ps2_data,
   input  logic                            rd_en,
   input  logic                            clr_err,
   output logic [7:0]                      code,
   output logic                            is_break,
   output logic                            is_ext,
   output logic                            valid,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            parity_err,
   output logic                            frame_err,
   output logic                            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] dat_sync_q;
   logic                   clk_s;
   logic                   dat_s;
   logic [FW-1:0]          filt_cnt_q;
   logic                   filt_q;
   logic                   prev_q;
   logic                   fall;

   state_t                 state_q;
   logic [7:0]             shift_q;
   logic [2:0]             bit_cnt_q;
   logic                   par_q;
   logic [TW-1:0]          to_cnt_q;
   logic                   good_q;
   logic                   err_q;
   logic                   parity_err_q;
   logic                   frame_err_q;

   logic                   ext_pend_q;
   logic                   brk_pend_q;
   logic                   dec_push;
   logic [9:0]             entry_d;

   logic [9:0]             mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q;
   logic [AW-1:0]          rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   overflow_q;
   logic                   full;
   logic                   pop;
   logic                   wr;

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   // Bring both pins into the clk domain; reset to the idle-high level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
      end else begin
         clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt_q <= '0;
         filt_q     <= 1'b1;
         prev_q     <= 1'b1;
      end else begin
         prev_q <= filt_q;
         if (clk_s == filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FILT_MAX) begin
            filt_q     <= clk_s;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = prev_q & ~filt_q;

   // Frame FSM: one step per filtered falling edge, with inactivity abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         good_q       <= 1'b0;
         err_q        <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         good_q <= 1'b0;
         err_q  <= 1'b0;
         // Clear first so that a same-cycle error below takes priority
         if (clr_err) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
         end
         if (fall) begin
            to_cnt_q <= '0;
            case (state_q)
               S_IDLE: begin
                  if (!dat_s) begin
                     state_q   <= S_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               S_DATA: begin
                  shift_q   <= {dat_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
               end
               S_PARITY: begin
                  par_q   <= dat_s;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  if (!dat_s) begin
                     frame_err_q <= 1'b1;
                     err_q       <= 1'b1;
                  end else if (^{par_q, shift_q}) begin
                     good_q <= 1'b1;
                  end else begin
                     parity_err_q <= 1'b1;
                     err_q        <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end else if (state_q != S_IDLE) begin
            if (to_cnt_q == TO_MAX) begin
               state_q  <= S_IDLE;
               to_cnt_q <= '0;
            end else begin
               to_cnt_q <= to_cnt_q + 1'b1;
            end
         end else begin
            to_cnt_q <= '0;
         end
      end
   end

   // shift_q is stable during the decoder cycle, so it doubles as the received byte
   assign dec_push = good_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);
   assign entry_d  = {ext_pend_q, brk_pend_q, shift_q};

   // Prefix tracking: E0/F0 arm flags that attach to the next real code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
      end else if (err_q) begin
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
      end else if (good_q) begin
         case (shift_q)
            8'hE0:   ext_pend_q <= 1'b1;
            8'hF0:   brk_pend_q <= 1'b1;
            default: begin
               ext_pend_q <= 1'b0;
               brk_pend_q <= 1'b0;
            end
         endcase
      end
   end

   assign full = (count_q == DEPTH_C);
   assign pop  = rd_en && (count_q != '0);
   assign wr   = dec_push && (!full || pop);

   // Event storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (wr) begin
         mem_q[wr_ptr_q] <= entry_d;
      end
   end

   // Pointers, occupancy and overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (clr_err) overflow_q <= 1'b0;
         if (dec_push && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign {is_ext, is_break, code} = mem_q[rd_ptr_q];
   assign valid      = (count_q != '0);
   assign fifo_count = count_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed self-checking bench for ps2_keyboard_rx
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

   localparam int HALF = 20;
   localparam int TO   = 1000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] code;
   logic       is_break;
   logic       is_ext;
   logic       valid;
   logic [3:0] fifo_count;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   ps2_keyboard_rx #(
      .FIFO_DEPTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_en(rd_en), .clr_err(clr_err), .code(code), .is_break(is_break),
      .is_ext(is_ext), .valid(valid), .fifo_count(fifo_count),
      .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~(^b) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      idle(HALF);
   endtask

   task automatic pop1();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      idle(3);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_head", {is_ext, is_break, code}, 0);
      check_eq("rst_flags", {parity_err, frame_err, overflow}, 0);
      rst_n = 1'b1;
      idle(5);

      // Single make code
      send(8'h1C, 1'b0, 1'b0);
      check_eq("t1_count", fifo_count, 1);
      check_eq("t1_head", {is_ext, is_break, code}, {2'b00, 8'h1C});
      pop1();
      check_eq("t1_valid_after_pop", valid, 0);
      pop1();
      check_eq("t1_pop_empty", fifo_count, 0);

      // Prefix folding
      send(8'hF0, 1'b0, 1'b0);
      send(8'h1C, 1'b0, 1'b0);
      send(8'hE0, 1'b0, 1'b0);
      send(8'hF0, 1'b0, 1'b0);
      send(8'h75, 1'b0, 1'b0);
      check_eq("t2_count", fifo_count, 2);
      check_eq("t2_head0", {is_ext, is_break, code}, {2'b01, 8'h1C});
      pop1();
      check_eq("t2_head1", {is_ext, is_break, code}, {2'b11, 8'h75});
      pop1();
      check_eq("t2_empty", fifo_count, 0);

      // Parity error, clear, and prefix cancel by error
      send(8'h1C, 1'b1, 1'b0);
      check_eq("t3_no_entry", fifo_count, 0);
      check_eq("t3_perr", parity_err, 1);
      pulse_clr();
      check_eq("t3_perr_clr", parity_err, 0);
      send(8'hF0, 1'b0, 1'b0);
      send(8'h1C, 1'b1, 1'b0);
      send(8'h1C, 1'b0, 1'b0);
      check_eq("t3_prefix_cleared", {is_ext, is_break, code}, {2'b00, 8'h1C});
      pop1();
      pulse_clr();

      // Framing error
      send(8'h1C, 1'b0, 1'b1);
      check_eq("t3_ferr", {frame_err, parity_err, fifo_count}, {2'b10, 4'd0});
      pulse_clr();
      check_eq("t3_ferr_clr", frame_err, 0);

      // Timeout on partial frame, then clock glitch rejection
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      idle(TO + 200);
      check_eq("t5_flags", {parity_err, frame_err, overflow}, 0);
      check_eq("t5_count", fifo_count, 0);
      ps2_data = 1'b0;
      idle(5);
      @(negedge clk) ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
      idle(10);
      ps2_data = 1'b1;
      idle(5);
      send(8'h29, 1'b0, 1'b0);
      check_eq("t5_count29", fifo_count, 1);
      check_eq("t5_head29", {is_ext, is_break, code}, {2'b00, 8'h29});
      check_eq("t5_no_err", {parity_err, frame_err}, 0);
      pop1();

      // Fill past capacity
      for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 1'b0, 1'b0);
      check_eq("t4_full", fifo_count, 8);
      check_eq("t4_ovf", overflow, 1);
      check_eq("t4_head", code, 8'h15);
      pulse_clr();
      check_eq("t4_ovf_clr", overflow, 0);
      fork
         send(8'h30, 1'b0, 1'b0);
         begin
            int n;
            n = 0;
            while (dut.dec_push !== 1'b1 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check_eq("t4_push_seen", n < 2000, 1);
            rd_en = 1'b1;
            @(negedge clk) rd_en = 1'b0;
         end
      join
      check_eq("t4_full_pushpop", fifo_count, 8);
      check_eq("t4_no_ovf", overflow, 0);
      for (int i = 0; i < 5; i++) begin
         check_eq("t4_drain", code, 8'h16 + 8'(i));
         pop1();
      end
      check_eq("t4_left", fifo_count, 3);
      check_eq("t4_head_after", code, 8'h1B);

      // Reset mid-frame with entries queued
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      idle(3);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_count", fifo_count, 0);
      check_eq("t6_rst_out", {valid, is_ext, is_break, code, parity_err, frame_err, overflow}, 0);
      idle(3);
      rst_n = 1'b1;
      ps2_data = 1'b1;
      idle(5);
      send(8'h1C, 1'b0, 1'b0);
      check_eq("t6_count", fifo_count, 1);
      check_eq("t6_head", {is_ext, is_break, code}, {2'b00, 8'h1C});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Second-generation PS/2 keyboard receiver, fully synchronous to the processor clock.
- Oversamples the asynchronous ps2_clk/ps2_data pins and filters glitches on the PS/2 clock.
- Checks the full 11-bit frame (start, 8 data bits LSB first, odd parity, stop) and folds E0/F0 prefixes into flags.
- Queues decoded key events in a show-ahead FIFO for the processor to read over a simple pop interface.

Parameters:
- FIFO_DEPTH, 8, number of queued key events; power of two, ≥2.
- SYNC_STAGES, 2, flip-flop synchroniser depth on ps2_clk and ps2_data; ≥2.
- FILTER_LEN, 4, consecutive identical synchronised samples required before the filtered ps2_clk changes.
- TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge before a partial frame is aborted.

Ports:
- clk  in  1  processor clock; the only clock in the block.
- rst_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw keyboard clock pin; asynchronous to clk; idles high.
- ps2_data  in  1  raw keyboard data pin; asynchronous to clk; idles high.
- rd_en  in  1  pops the FIFO head on the clk edge where it is sampled high.
- clr_err  in  1  clears parity_err, frame_err and overflow.
- code  out  8  scancode at the FIFO head.
- is_break  out  1  head entry was preceded by F0 (key release).
- is_ext  out  1  head entry was preceded by E0 (extended key).
- valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- parity_err  out  1  sticky flag.
- frame_err  out  1  sticky flag.
- overflow  out  1  sticky flag.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, FIFO empty, FSM in IDLE, prefix flags cleared.
  - Filtered clock and last-sample register set to 1.
- Input path:
  - Each pin passes through SYNC_STAGES flops.
  - Filtered clock takes the synchronised value once FILTER_LEN consecutive samples agree; pulses shorter than that are ignored.
  - A filtered-clock falling edge produces a 1-cycle fall pulse.
  - Data is sampled from the synchronised ps2_data in the cycle of the fall pulse.
- Frame FSM (advances only on fall pulses):
  - IDLE: data=0 goes to DATA with bit count=0. data=1 stays in IDLE (stray edge, no error).
  - DATA: shift in 8 bits LSB first; after bit 7, go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP:
    - data=1 and odd parity over 9 bits: byte is good.
    - data=1 and parity bad: set parity_err, drop the byte.
    - data=0: set frame_err, drop the byte (parity not checked).
    - Always returns to IDLE.
  - Timeout: a cycle counter is cleared on every fall pulse and runs in any non-IDLE state. Reaching TIMEOUT_CYCLES forces IDLE, discards the partial byte, leaves flags unchanged, and does not touch the prefix flags.
- Decoder (acts in the cycle after a good byte):
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte requests a push of {ext_pend, brk_pend, byte} and clears both pend flags.
  - A parity or frame error clears both pend flags.
- FIFO and read interface:
  - Push is written on the decoder cycle; valid and fifo_count update on the next clk edge. Latency from the stop-bit fall pulse to valid=1 is 2 clk cycles.
  - Show-ahead: code, is_break and is_ext always present the head entry. They hold their last value when empty and are not checked while valid=0.
  - rd_en while empty is ignored.
  - Push while full with no pop: the entry is dropped, overflow is set, contents unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags:
  - clr_err clears all flags the next cycle.
  - If clr_err coincides with a new error, the error wins (flag stays 1).

Test Plan:
- Frame 0x1C (parity bit 0), ps2_clk period 80 µs → one entry: code=1C, is_break=0, is_ext=0, fifo_count=1; rd_en for one cycle → valid=0.
- Bytes F0,1C then E0,F0,75 → two entries: {1C, brk=1, ext=0} and {75, brk=1, ext=1}; no entry is produced for the prefixes.
- 0x1C sent with parity bit 1 → no entry, parity_err=1. Then clr_err → 0. A following F0 prefix is cleared if the error lands between it and its code.
- FIFO_DEPTH+1 make codes 0x15,0x16,… with no rd_en → fifo_count=8, overflow=1, head code=15. Push and pop in the same cycle while full → count stays 8, overflow not re-set after clr_err.
- Start bit plus 4 data bits, then idle > TIMEOUT_CYCLES → FSM in IDLE, no flags set. Next frame 0x29 → entry code=29. A 2-cycle low glitch on ps2_clk (< FILTER_LEN) → no bit shifted.
- rst_n low for 3 cycles mid-frame with 3 entries queued → all outputs 0 immediately. After release, a fresh 0x1C frame → single entry 1C.
